// File: rtl/q15_spi_dac_tx.sv
// q15_spi_dac_tx: FIFO-buffered Q1.15 sample sink that emits each sample as a 16-bit SPI mode-0 frame.
// Build option: define Q15_DAC_OFFSET_BIN_EN to transmit offset-binary words for unipolar DACs.
module q15_spi_dac_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_GAP  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [15:0]                       sample_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic                              dac_sclk,
  output logic                              dac_cs_n,
  output logic                              dac_mosi,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy
);

  // state | meaning
  // IDLE  | bus idle, chip select high, waiting for a queued sample
  // SHIFT | frame in progress, SCLK toggles every CLK_DIV cycles
  // GAP   | chip select held high for FRAME_GAP cycles before the next frame
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(FRAME_GAP - 1);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [15:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [7:0]    div_cnt;
  logic [7:0]    gap_cnt;
  logic          push;
  logic          pop;
  logic [15:0]   head_word;

  assign ready_in = rst_n && (fifo_level < LW'(FIFO_DEPTH));
  assign push     = valid_in && ready_in;
  assign pop      = (state == IDLE) && (fifo_level != '0);
  assign busy     = (state != IDLE) || (fifo_level != '0);

`ifdef Q15_DAC_OFFSET_BIN_EN
  assign head_word = {~mem[rd_ptr][15], mem[rd_ptr][14:0]};
`else
  assign head_word = mem[rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Timers are down-counters: load N-1, act on reaching zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dac_sclk <= 1'b0;
      dac_cs_n <= 1'b1;
      dac_mosi <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= head_word;
            dac_cs_n <= 1'b0;
            dac_mosi <= head_word[15];
            bit_cnt  <= 4'd15;
            div_cnt  <= DIV_LOAD;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt  <= DIV_LOAD;
            dac_sclk <= ~dac_sclk;
            // Data only moves on the falling toggle so it is stable at every rise.
            if (dac_sclk) begin
              if (bit_cnt != 4'd0) begin
                shreg    <= {shreg[14:0], 1'b0};
                dac_mosi <= shreg[14];
                bit_cnt  <= bit_cnt - 4'd1;
              end else begin
                dac_cs_n <= 1'b1;
                dac_mosi <= 1'b0;
                gap_cnt  <= GAP_LOAD;
                state    <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
          else                 state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q15_spi_dac_tx.sv
// Scoreboard bench for q15_spi_dac_tx: two instances (default timing and CLK_DIV=1/FRAME_GAP=3).
module tb_q15_spi_dac_tx;
  localparam int D0 = 2;
  localparam int G0 = 1;
  localparam int D1 = 1;
  localparam int G1 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din [2];
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [1:0]  busy;
  logic [2:0]  lvl0;
  logic [2:0]  lvl1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q [2][$];
  int frames [2];
  int rises [2];
  int gap_len [2];
  bit in_frame [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  q15_spi_dac_tx #(.CLK_DIV(D0), .FIFO_DEPTH(4), .FRAME_GAP(G0)) u_dac0 (
    .clk(clk), .rst_n(rst_n), .sample_in(din[0]), .valid_in(valid[0]), .ready_in(ready[0]),
    .dac_sclk(sclk[0]), .dac_cs_n(cs_n[0]), .dac_mosi(mosi[0]), .fifo_level(lvl0), .busy(busy[0])
  );

  q15_spi_dac_tx #(.CLK_DIV(D1), .FIFO_DEPTH(4), .FRAME_GAP(G1)) u_dac1 (
    .clk(clk), .rst_n(rst_n), .sample_in(din[1]), .valid_in(valid[1]), .ready_in(ready[1]),
    .dac_sclk(sclk[1]), .dac_cs_n(cs_n[1]), .dac_mosi(mosi[1]), .fifo_level(lvl1), .busy(busy[1])
  );

  // Word the DAC should receive: offset binary is the sample plus half scale, mod 2^16.
  function automatic logic [15:0] dac_word(input logic [15:0] s);
`ifdef Q15_DAC_OFFSET_BIN_EN
    return s + 16'h8000;
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic monitor(input int k);
    int d;
    bit pcs;
    bit psc;
    int t_start;
    int t_end;
    int nr;
    bit have_end;
    logic [15:0] word;
    logic [15:0] e;
    d = (k == 0) ? D0 : D1;
    pcs = 1'b1; psc = 1'b0; t_start = 0; t_end = 0; nr = 0; have_end = 1'b0; word = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_q[k].delete();
        in_frame[k] = 1'b0;
        have_end = 1'b0;
        pcs = 1'b1;
        psc = 1'b0;
        continue;
      end
      if (valid[k] && ready[k]) exp_q[k].push_back(dac_word(din[k]));
      if (cs_n[k]) check("sclk_low_while_cs_high", sclk[k], 0);
      if (pcs && !cs_n[k]) begin
        in_frame[k] = 1'b1;
        t_start = cyc;
        nr = 0;
        rises[k] = 0;
        word = '0;
        frames[k]++;
        if (have_end) gap_len[k] = cyc - t_end;
      end
      if (in_frame[k] && !psc && sclk[k]) begin
        nr++;
        rises[k] = nr;
        word = {word[14:0], mosi[k]};
        check("rise_time", cyc - t_start, d * (2 * nr - 1));
      end
      if (in_frame[k] && !pcs && cs_n[k]) begin
        check("rise_count", nr, 16);
        check("frame_len", cyc - t_start, 32 * d);
        check("frame_expected", exp_q[k].size() > 0, 1);
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          check("frame_word", word, e);
        end
        in_frame[k] = 1'b0;
        t_end = cyc;
        have_end = 1'b1;
      end
      pcs = cs_n[k];
      psc = sclk[k];
    end
  endtask

  task automatic send(input int k, input logic [15:0] v, output int edge_no);
    int t;
    bit took;
    t = 0; took = 1'b0;
    @(posedge clk); #1;
    din[k] = v;
    valid[k] = 1'b1;
    while (!took && t < 1000) begin
      @(negedge clk);
      took = ready[k];
      @(posedge clk); #1;
      t++;
    end
    valid[k] = 1'b0;
    edge_no = cyc;
    check("send_accept", took, 1);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy[k] || in_frame[k] || !cs_n[k]) && t < 3000);
    check("idle_timeout", t < 3000, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    int acc;
    int t;
    int f;
    bit took;
    bit lvl_chk;
    int e_arr [6];
    logic [15:0] s [6];
    logic [15:0] w;

    valid = '0;
    din[0] = '0;
    din[1] = '0;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset0", ready[0], 0);
    check("ready_in_reset1", ready[1], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_cs_n", cs_n[k], 1);
      check("rst_sclk", sclk[k], 0);
      check("rst_mosi", mosi[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_ready", ready[k], 1);
    end
    check("rst_level0", lvl0, 0);
    check("rst_level1", lvl1, 0);

    // Single sample latency and frame envelope
    send(0, 16'hA55A, e0);
    @(negedge clk);
    check("cs_before_pop", cs_n[0], 1);
    check("level_after_push", lvl0, 1);
    @(negedge clk);
    w = dac_word(16'hA55A);
    check("cs_low_after_pop", cs_n[0], 0);
    check("level_after_pop", lvl0, 0);
    check("first_mosi", mosi[0], w[15]);
    repeat (63) @(negedge clk);
    check("cs_low_last_cycle", cs_n[0], 0);
    @(negedge clk);
    check("cs_high_after_frame", cs_n[0], 1);
    check("busy_in_gap", busy[0], 1);
    @(negedge clk);
    check("busy_after_gap", busy[0], 0);

    // Backpressure: valid held high across six samples
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) s[i] = 16'($urandom);
    acc = 0; t = 0; lvl_chk = 1'b0;
    din[0] = s[0];
    valid[0] = 1'b1;
    while (acc < 6 && t < 1000) begin
      @(negedge clk);
      if (acc == 5 && !lvl_chk) begin
        check("full_level", lvl0, 4);
        check("full_ready", ready[0], 0);
        lvl_chk = 1'b1;
      end
      took = ready[0];
      @(posedge clk); #1;
      t++;
      if (took) begin
        e_arr[acc] = cyc;
        acc++;
        if (acc < 6) din[0] = s[acc];
      end
    end
    valid[0] = 1'b0;
    check("burst_accepted", acc, 6);
    for (int i = 1; i < 5; i++) check("burst_accept_edge", e_arr[i] - e_arr[0], i);
    check("burst_s5_edge", e_arr[5] - e_arr[0], 68);
    wait_idle(0);
    check("gap_len_div2", gap_len[0], G0 + 1);
    check("burst_queue_drained", exp_q[0].size(), 0);

    // CLK_DIV=1, FRAME_GAP=3, two queued samples
    send(1, 16'h8001, e1);
    send(1, 16'($urandom), e1);
    wait_idle(1);
    check("gap_len_gap3", gap_len[1], G1 + 1);
    check("div1_queue_drained", exp_q[1].size(), 0);

    // Full-scale extremes
    send(0, 16'h7FFF, e0);
    send(0, 16'h8000, e0);
    send(0, 16'h0000, e0);
    wait_idle(0);

    // Random traffic on both instances
    for (int i = 0; i < 12; i++) begin
      send(int'($urandom_range(0, 1)), 16'($urandom), e0);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_idle(0);
    wait_idle(1);
    check("random_queue0_drained", exp_q[0].size(), 0);
    check("random_queue1_drained", exp_q[1].size(), 0);

    // Reset in the middle of a frame with samples queued
    for (int i = 0; i < 4; i++) send(0, 16'($urandom), e0);
    check("queued_before_reset", lvl0, 3);
    t = 0;
    while (!(in_frame[0] && rises[0] >= 7) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("seventh_rise_seen", rises[0], 7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    valid[0] = 1'b1;
    din[0] = 16'($urandom);
    @(negedge clk);
    check("ready_in_mid_reset", ready[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid[0] = 1'b0;
    @(negedge clk);
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_mosi", mosi[0], 0);
    check("abort_level", lvl0, 0);
    check("abort_busy", busy[0], 0);
    f = frames[0];
    repeat (150) @(negedge clk);
    check("no_frames_after_flush", frames[0], f);
    check("bus_idle_after_flush", cs_n[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
